// File: rtl/pattern_gen_pkg.sv
// Shared types, seed constants and next-value function for the pattern generator.
package pattern_gen_pkg;

  // Widest pattern the helper functions handle; WIDTH must not exceed this.
  localparam int PG_MAX_W = 64;

  typedef enum logic [1:0] {
    COUNT_UP   = 2'd0,
    COUNT_DOWN = 2'd1,
    WALK_ONE   = 2'd2,
    LFSR       = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GAP   = 2'd1,
    VALID = 2'd2
  } state_t;

  // Seeds are full-width; callers truncate to their own WIDTH (DOWN stays all-ones).
  localparam logic [PG_MAX_W-1:0] SEED_UP   = '0;
  localparam logic [PG_MAX_W-1:0] SEED_DOWN = '1;
  localparam logic [PG_MAX_W-1:0] SEED_WALK = 64'd1;
  localparam logic [PG_MAX_W-1:0] SEED_LFSR = 64'd1;

  function automatic logic [PG_MAX_W-1:0] seed_of(mode_t m);
    logic [PG_MAX_W-1:0] s;
    case (m)
      COUNT_UP:   s = SEED_UP;
      COUNT_DOWN: s = SEED_DOWN;
      WALK_ONE:   s = SEED_WALK;
      default:    s = SEED_LFSR;
    endcase
    return s;
  endfunction

  // Next pattern value for a width-bit generator; result is masked to width bits.
  function automatic logic [PG_MAX_W-1:0] next_pattern(mode_t mode,
                                                        logic [PG_MAX_W-1:0] value,
                                                        int unsigned width,
                                                        logic [PG_MAX_W-1:0] taps);
    logic [PG_MAX_W-1:0] mask;
    logic [PG_MAX_W-1:0] r;
    mask = (width >= PG_MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
    case (mode)
      COUNT_UP:   r = value + 64'd1;
      COUNT_DOWN: r = value - 64'd1;
      WALK_ONE:   r = (value << 1) | (value >> (width - 1));
      default:    r = (value >> 1) ^ (value[0] ? taps : '0);
    endcase
    return r & mask;
  endfunction

endpackage

// File: rtl/pattern_gen_presc.sv
// Loadable down-counter that paces the idle gap between beats; tick flags zero.
module pattern_gen_presc #(
  parameter int DIV_W = 16
) (
  input  logic             ref_clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [DIV_W-1:0] load_val,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_d, cnt_q;

  // Load has priority; otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load)                   cnt_d = load_val;
    else if (dec && cnt_q != '0) cnt_d = cnt_q - DIV_W'(1);
  end

  // Counter register.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/pattern_gen.sv
// Burst pattern generator: paced beats of count/walk/LFSR data over valid/ready.
module pattern_gen
  import pattern_gen_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DIV_W     = 16,
  parameter int               LEN_W     = 16,
  parameter logic [WIDTH-1:0] LFSR_TAPS = 8'hB8
) (
  input  logic             ref_clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  input  logic [LEN_W-1:0] burst_len,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  state_t           state_d, state_q;
  mode_t            mode_d, mode_q;
  logic [DIV_W-1:0] div_d, div_q;
  logic [LEN_W-1:0] len_d, len_q;
  logic [LEN_W-1:0] cnt_d, cnt_q, cnt_inc;
  logic [WIDTH-1:0] out_d, out_q, out_nxt, out_seed;
  logic             out_valid_d, out_valid_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;
  logic             presc_load, presc_tick;
  logic [DIV_W-1:0] presc_val;
  logic             hs, last;

  assign hs       = (state_q == VALID) && out_ready;
  assign cnt_inc  = cnt_q + LEN_W'(1);
  assign last     = (len_q != '0) && (cnt_inc == len_q);
  assign out_nxt  = WIDTH'(next_pattern(mode_q, PG_MAX_W'(out_q), WIDTH, PG_MAX_W'(LFSR_TAPS)));
  assign out_seed = WIDTH'(seed_of(mode_t'(mode)));

  pattern_gen_presc #(.DIV_W(DIV_W)) u_presc (
    .ref_clk  (ref_clk),
    .rst_n    (rst_n),
    .load     (presc_load),
    .dec      (state_q == GAP),
    .load_val (presc_val),
    .tick     (presc_tick)
  );

  // Burst sequencing: latch config on start, pace via prescaler, advance on handshake.
  // A burst-ending handshake leaves out on the delivered beat so IDLE shows it.
  // Between beats the prescaler is reloaded with div-1 so exactly div idle
  // cycles separate them; the first beat additionally waits the start cycle.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    div_d      = div_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    out_d      = out_q;
    done_d     = 1'b0;
    presc_load = 1'b0;
    presc_val  = div_q;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          mode_d     = mode_t'(mode);
          div_d      = div;
          len_d      = burst_len;
          cnt_d      = '0;
          out_d      = out_seed;
          presc_load = 1'b1;
          presc_val  = div;
          state_d    = GAP;
        end
      end
      GAP: begin
        if (stop)            state_d = IDLE;
        else if (presc_tick) state_d = VALID;
      end
      VALID: begin
        if (hs) begin
          cnt_d = cnt_inc;
          if (stop) begin
            state_d = IDLE;
          end else if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            out_d = out_nxt;
            if (div_q != '0) begin
              presc_load = 1'b1;
              presc_val  = div_q - DIV_W'(1);
              state_d    = GAP;
            end
          end
        end else if (stop) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == VALID);
    busy_d      = (state_d != IDLE);
  end

  // State, latched configuration and registered outputs.
  always_ff @(posedge ref_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mode_q      <= COUNT_UP;
      div_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      div_q       <= div_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
